axis_iq_deinterleaver: RTL and testbench
========================================

Name: axis_iq_deinterleaver

Overview:
Source side of the beamforming weight multiplier's paired real/imag AXI-stream slave ports. Accepts 128-bit interleaved complex samples from a DMA MM2S channel: 4 complex samples per beat, each as 16-bit I and 16-bit Q. Emits lock-stepped 128-bit real and imag streams, 8 samples per beat, sharing one valid and carrying tlast. Two input beats form one output beat; odd-length packets are zero-padded and flagged via tkeep.

Parameters:
SDATA_WIDTH, 128, input beat width
SAMPLE_WIDTH, 16, width of one I or Q component
MDATA_WIDTH, 128, output beat width per stream (= 2*SDATA_WIDTH/2)
CSAMPLES, SDATA_WIDTH/(2*SAMPLE_WIDTH) = 4, complex samples per input beat
SAMPLES, MDATA_WIDTH/SAMPLE_WIDTH = 8, samples per output beat
Q_FIRST, 0, 0: lane k I at [32k +:16], Q at [32k+16 +:16]; 1: swapped

Ports:
clock  in  1  clock
resetn  in  1  reset; synchronous, active-low
s_axis_mm2s_tdata  in  SDATA_WIDTH  interleaved IQ beat
s_axis_mm2s_tvalid  in  1  input valid
s_axis_mm2s_tready  out  1  input ready
s_axis_mm2s_tlast  in  1  last beat of packet
m_axis_real_tdata  out  MDATA_WIDTH  8 real samples, sample j at [16j +:16]
m_axis_real_tkeep  out  MDATA_WIDTH/8  byte enables
m_axis_real_tvalid  out  1  real valid
m_axis_real_tlast  out  1  real last
m_axis_real_tready  in  1  real ready
m_axis_imag_tdata  out  MDATA_WIDTH  8 imag samples
m_axis_imag_tkeep  out  MDATA_WIDTH/8  byte enables
m_axis_imag_tvalid  out  1  imag valid
m_axis_imag_tlast  out  1  imag last
m_axis_imag_tready  in  1  imag ready
pkt_count  out  16  completed output packets, wraps at 65535->0

Behaviour:
- Reset (resetn=0 at posedge): state FILL_LO; half buffer cleared; all m_axis_* tdata/tkeep/tvalid/tlast = 0; pkt_count = 0. s_axis_mm2s_tready forced 0 combinationally while resetn=0.
- Reset mid-operation: any buffered half beat and any pending output beat are discarded, not emitted.
- Output register is one beat shared by both streams. Real and imag tvalid are always equal.
- drain = tvalid & m_axis_real_tready & m_axis_imag_tready. Both readies are required in the same cycle; a single ready never drains.
- out_free = !tvalid | drain.
- FSM states:
  - FILL_LO:
    - tready = 1.
    - On accept, store 4 I samples in lo_re and 4 Q samples in lo_im.
    - tlast=0 -> FILL_HI; tlast=1 -> FLUSH.
  - FILL_HI:
    - tready = out_free.
    - On accept, load output: real = {I3..I0 of this beat, lo_re}; imag likewise; tkeep = 16'hFFFF; tlast = s_tlast; tvalid = 1.
    - Next state FILL_LO.
  - FLUSH:
    - tready = 0.
    - When out_free, load real = {64'h0, lo_re}, imag = {64'h0, lo_im}, tkeep = 16'h00FF, tlast = 1, tvalid = 1.
    - Next state FILL_LO.
- Latency: output valid the cycle after the second input beat is accepted, or the cycle after entering FLUSH if out_free.
- Throughput: sustained 1 output per 2 input beats, no bubbles when both readies are held high.
- Hold: if drain is false, the output tdata/tkeep/tlast/tvalid hold unchanged (AXIS stability). A load in the same cycle as a drain replaces the beat with no gap.
- If a drain occurs with no new load, tvalid -> 0; tdata is left unchanged (don't-care).
- pkt_count increments on drain with tlast=1.
- Ordering: sample j=0 of output is the lowest lane of the first input beat of the pair.
- No arithmetic; pure bit rearrangement. Q_FIRST only selects the lane offsets.

Decomposition:
- Shared package: SAMPLE_WIDTH, SDATA_WIDTH, MDATA_WIDTH, derived CSAMPLES/SAMPLES, FSM state enum (FILL_LO, FILL_HI, FLUSH), tkeep constants KEEP_FULL = 16'hFFFF and KEEP_LO = 16'h00FF.
- One sub-module, iq_beat_unpack: combinational; takes one input beat plus Q_FIRST and returns 64-bit re and im halves. It is instantiated once on s_axis_mm2s_tdata.

Test Plan:
- Reset: hold resetn=0 for 3 cycles while tvalid=1 -> tready=0, all outputs 0, pkt_count=0.
- Basic pair: beat0 = {Q3,I3..Q0,I0} with I=1..4, Q=0x101..0x104; beat1 I=5..8, Q=0x105..0x108, tlast=1; both readies=1 -> one cycle later real=0x0008..0001 (sample0=1), imag=0x0108..0x0101, tkeep=FFFF, tlast=1, pkt_count=1.
- Odd packet: 3 beats, tlast on beat 3 (I=9..12) -> second output real={64'h0, 000C000B000A0009}, tkeep=00FF, tlast=1; FLUSH lasts 1 cycle with tready=0.
- Backpressure: real_tready=1, imag_tready=0 for 5 cycles -> output held stable, no drain; FILL_HI tready=0; FILL_LO still accepts one beat; when imag_tready=1, drain occurs and the next pair loads in the same cycle.
- Streaming: 64 beats, tlast on beat 64, readies held 1 -> 32 outputs on consecutive odd cycles, tlast only on the 32nd, pkt_count=1; with Q_FIRST=1, real and imag contents swap.
- Reset mid-packet: assert resetn=0 after beat0 and during a pending output -> no output emitted, state FILL_LO; a subsequent 2-beat packet is emitted correctly.

Source files
------------

// File: rtl/axis_iq_deinterleaver_pkg.sv
// Shared widths, FSM encodings, keep constants and the output beat record.
// Latency: none (declarations only).
// Backpressure: not applicable.
package axis_iq_deinterleaver_pkg;

    localparam int SAMPLE_WIDTH = 16;
    localparam int SDATA_WIDTH  = 128;
    localparam int MDATA_WIDTH  = 128;
    localparam int CSAMPLES     = SDATA_WIDTH / (2 * SAMPLE_WIDTH);
    localparam int SAMPLES      = MDATA_WIDTH / SAMPLE_WIDTH;
    localparam int HALF_WIDTH   = CSAMPLES * SAMPLE_WIDTH;
    localparam int KEEP_WIDTH   = MDATA_WIDTH / 8;

    typedef logic [1:0] state_t;
    localparam state_t FILL_LO = 2'd0;
    localparam state_t FILL_HI = 2'd1;
    localparam state_t FLUSH   = 2'd2;

    localparam logic [KEEP_WIDTH-1:0] KEEP_FULL = 16'hFFFF;
    localparam logic [KEEP_WIDTH-1:0] KEEP_LO   = 16'h00FF;

    // One output beat, shared by the real and imag streams.
    typedef struct packed {
        logic [MDATA_WIDTH-1:0] re;
        logic [MDATA_WIDTH-1:0] im;
        logic [KEEP_WIDTH-1:0]  keep;
        logic                   last;
    } out_beat_t;

endpackage

// File: rtl/axis_iq_deinterleaver_unpack.sv
// Splits one interleaved IQ beat into packed I and Q halves (lane 0 lowest).
// Latency: combinational.
// Backpressure: none; pure wiring.
// Ports: beat (SDATA_WIDTH in), re / im (HALF_WIDTH out).
module iq_beat_unpack
    import axis_iq_deinterleaver_pkg::*;
#(
    parameter int Q_FIRST = 0
) (
    input  logic [SDATA_WIDTH-1:0] beat,
    output logic [HALF_WIDTH-1:0]  re,
    output logic [HALF_WIDTH-1:0]  im
);

    // Offset of each component inside its 32-bit complex lane.
    localparam int RE_OFS = (Q_FIRST != 0) ? SAMPLE_WIDTH : 0;
    localparam int IM_OFS = SAMPLE_WIDTH - RE_OFS;

    always_comb begin
        re = '0;
        im = '0;
        for (int k = 0; k < CSAMPLES; k++) begin
            re[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = beat[2*k*SAMPLE_WIDTH + RE_OFS +: SAMPLE_WIDTH];
            im[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = beat[2*k*SAMPLE_WIDTH + IM_OFS +: SAMPLE_WIDTH];
        end
    end

endmodule

// File: rtl/axis_iq_deinterleaver.sv
// Deinterleaves 4-sample IQ beats into lock-stepped 8-sample real/imag streams.
// Latency: output valid one cycle after the second beat of a pair (or the flush).
// Backpressure: drains only when both output readies are high; input stalls on a full output.
// Ports: clock, resetn (sync, active-low); s_axis_mm2s_* interleaved input;
//        m_axis_real_* / m_axis_imag_* split outputs sharing one valid; pkt_count.
module axis_iq_deinterleaver
    import axis_iq_deinterleaver_pkg::*;
#(
    parameter int Q_FIRST = 0
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [SDATA_WIDTH-1:0]  s_axis_mm2s_tdata,
    input  logic                    s_axis_mm2s_tvalid,
    output logic                    s_axis_mm2s_tready,
    input  logic                    s_axis_mm2s_tlast,
    output logic [MDATA_WIDTH-1:0]  m_axis_real_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_real_tkeep,
    output logic                    m_axis_real_tvalid,
    output logic                    m_axis_real_tlast,
    input  logic                    m_axis_real_tready,
    output logic [MDATA_WIDTH-1:0]  m_axis_imag_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_imag_tkeep,
    output logic                    m_axis_imag_tvalid,
    output logic                    m_axis_imag_tlast,
    input  logic                    m_axis_imag_tready,
    output logic [15:0]             pkt_count
);

    state_t                 state;
    logic [HALF_WIDTH-1:0]  lo_re;
    logic [HALF_WIDTH-1:0]  lo_im;
    logic [HALF_WIDTH-1:0]  un_re;
    logic [HALF_WIDTH-1:0]  un_im;
    out_beat_t              out_q;
    out_beat_t              load_beat;
    logic                   out_vld;
    logic                   drain;
    logic                   out_free;
    logic                   accept;
    logic                   load;

    iq_beat_unpack #(
        .Q_FIRST (Q_FIRST)
    ) u_unpack (
        .beat (s_axis_mm2s_tdata),
        .re   (un_re),
        .im   (un_im)
    );

    // A lone ready never drains: both streams must take the beat together.
    assign drain    = out_vld & m_axis_real_tready & m_axis_imag_tready;
    assign out_free = ~out_vld | drain;

    always_comb begin
        s_axis_mm2s_tready = 1'b0;
        if (resetn) begin
            case (state)
                FILL_LO: s_axis_mm2s_tready = 1'b1;
                FILL_HI: s_axis_mm2s_tready = out_free;
                default: s_axis_mm2s_tready = 1'b0;
            endcase
        end
    end

    assign accept = s_axis_mm2s_tvalid & s_axis_mm2s_tready;
    assign load   = ((state == FILL_HI) & accept) | ((state == FLUSH) & out_free);

    // FLUSH pads the missing upper half with zeros and marks only the low bytes.
    always_comb begin
        load_beat = '0;
        if (state == FLUSH) begin
            load_beat.re   = {{HALF_WIDTH{1'b0}}, lo_re};
            load_beat.im   = {{HALF_WIDTH{1'b0}}, lo_im};
            load_beat.keep = KEEP_LO;
            load_beat.last = 1'b1;
        end else begin
            load_beat.re   = {un_re, lo_re};
            load_beat.im   = {un_im, lo_im};
            load_beat.keep = KEEP_FULL;
            load_beat.last = s_axis_mm2s_tlast;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= FILL_LO;
            lo_re     <= '0;
            lo_im     <= '0;
            out_q     <= '0;
            out_vld   <= 1'b0;
            pkt_count <= '0;
        end else begin
            case (state)
                FILL_LO: begin
                    if (accept) begin
                        lo_re <= un_re;
                        lo_im <= un_im;
                        state <= s_axis_mm2s_tlast ? FLUSH : FILL_HI;
                    end
                end
                FILL_HI: begin
                    if (accept) begin
                        state <= FILL_LO;
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        state <= FILL_LO;
                    end
                end
                default: state <= FILL_LO;
            endcase

            // A load coinciding with a drain replaces the beat with no bubble.
            if (load) begin
                out_q   <= load_beat;
                out_vld <= 1'b1;
            end else if (drain) begin
                out_vld <= 1'b0;
            end

            if (drain && out_q.last) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

    assign m_axis_real_tdata  = out_q.re;
    assign m_axis_real_tkeep  = out_q.keep;
    assign m_axis_real_tvalid = out_vld;
    assign m_axis_real_tlast  = out_q.last;
    assign m_axis_imag_tdata  = out_q.im;
    assign m_axis_imag_tkeep  = out_q.keep;
    assign m_axis_imag_tvalid = out_vld;
    assign m_axis_imag_tlast  = out_q.last;

endmodule

// File: tb/tb_axis_iq_deinterleaver.sv
// Bench for axis_iq_deinterleaver: two instances (I-first and Q-first lanes) on shared stimulus.
// Inputs change at the falling edge; outputs sampled 1 time unit after it.
// Expected beats queue up as stimulus is driven and are popped on every drain.
module tb_axis_iq_deinterleaver;

    logic         clock = 1'b0;
    logic         resetn;
    logic [127:0] s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic         q1_s_tready;
    logic         real_rdy;
    logic         imag_rdy;

    logic [127:0] r_data, i_data, q1_r_data, q1_i_data;
    logic [15:0]  r_keep, i_keep, q1_r_keep, q1_i_keep;
    logic         r_vld, i_vld, r_last, i_last;
    logic         q1_r_vld, q1_i_vld, q1_r_last, q1_i_last;
    logic [15:0]  pkt_count, q1_pkt_count;

    typedef struct {
        logic [127:0] re;
        logic [127:0] im;
        logic [15:0]  keep;
        logic         last;
    } exp_t;

    exp_t        sb[$];
    int          drain_cyc[$];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] exp_pkt = 16'd0;

    always #5 clock = ~clock;

    axis_iq_deinterleaver #(.Q_FIRST(0)) dut0 (
        .clock              (clock),
        .resetn             (resetn),
        .s_axis_mm2s_tdata  (s_tdata),
        .s_axis_mm2s_tvalid (s_tvalid),
        .s_axis_mm2s_tready (s_tready),
        .s_axis_mm2s_tlast  (s_tlast),
        .m_axis_real_tdata  (r_data),
        .m_axis_real_tkeep  (r_keep),
        .m_axis_real_tvalid (r_vld),
        .m_axis_real_tlast  (r_last),
        .m_axis_real_tready (real_rdy),
        .m_axis_imag_tdata  (i_data),
        .m_axis_imag_tkeep  (i_keep),
        .m_axis_imag_tvalid (i_vld),
        .m_axis_imag_tlast  (i_last),
        .m_axis_imag_tready (imag_rdy),
        .pkt_count          (pkt_count)
    );

    axis_iq_deinterleaver #(.Q_FIRST(1)) dut1 (
        .clock              (clock),
        .resetn             (resetn),
        .s_axis_mm2s_tdata  (s_tdata),
        .s_axis_mm2s_tvalid (s_tvalid),
        .s_axis_mm2s_tready (q1_s_tready),
        .s_axis_mm2s_tlast  (s_tlast),
        .m_axis_real_tdata  (q1_r_data),
        .m_axis_real_tkeep  (q1_r_keep),
        .m_axis_real_tvalid (q1_r_vld),
        .m_axis_real_tlast  (q1_r_last),
        .m_axis_real_tready (real_rdy),
        .m_axis_imag_tdata  (q1_i_data),
        .m_axis_imag_tkeep  (q1_i_keep),
        .m_axis_imag_tvalid (q1_i_vld),
        .m_axis_imag_tlast  (q1_i_last),
        .m_axis_imag_tready (imag_rdy),
        .pkt_count          (q1_pkt_count)
    );

    // Four consecutive 16-bit values starting at base, value base in the low lane.
    function automatic logic [63:0] half(input int base);
        logic [63:0] h;
        for (int k = 0; k < 4; k++) h[16*k +: 16] = 16'(base + k);
        return h;
    endfunction

    // Interleaved beat: lane k carries I=ib+k at [32k], Q=qb+k at [32k+16].
    function automatic logic [127:0] mk_beat(input int ib, input int qb);
        logic [127:0] b;
        for (int k = 0; k < 4; k++) begin
            b[32*k +: 16]      = 16'(ib + k);
            b[32*k + 16 +: 16] = 16'(qb + k);
        end
        return b;
    endfunction

    function automatic void push_pair(input int ib0, input int qb0, input int ib1, input int qb1,
                                      input logic last);
        exp_t e;
        e.re   = {half(ib1), half(ib0)};
        e.im   = {half(qb1), half(qb0)};
        e.keep = 16'hFFFF;
        e.last = last;
        sb.push_back(e);
        if (last) exp_pkt = exp_pkt + 16'd1;
    endfunction

    function automatic void push_flush(input int ib, input int qb);
        exp_t e;
        e.re   = {64'h0, half(ib)};
        e.im   = {64'h0, half(qb)};
        e.keep = 16'h00FF;
        e.last = 1'b1;
        sb.push_back(e);
        exp_pkt = exp_pkt + 16'd1;
    endfunction

    // Scoreboard: every drain of dut0 must match the head of the queue; the
    // Q-first instance sees the same lanes, so its real/imag are swapped.
    task automatic scoreboard_monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            cyc++;
            if (resetn === 1'b1 && r_vld === 1'b1 && real_rdy === 1'b1 && imag_rdy === 1'b1) begin
                drain_cyc.push_back(cyc);
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_beat: got real=%h with none required", r_data);
                end else begin
                    e = sb.pop_front();
                    compared++;
                    if ({r_data, i_data, r_keep, i_keep, r_last, i_last, i_vld} !==
                        {e.re, e.im, e.keep, e.keep, e.last, e.last, 1'b1}) begin
                        mismatched++;
                        $display("FAIL beat_iq: got re=%h im=%h keep=%h/%h last=%b/%b ivld=%b, required re=%h im=%h keep=%h last=%b",
                                 r_data, i_data, r_keep, i_keep, r_last, i_last, i_vld, e.re, e.im, e.keep, e.last);
                    end
                    compared++;
                    if ({q1_r_data, q1_i_data, q1_r_keep, q1_r_last, q1_r_vld, q1_i_vld} !==
                        {e.im, e.re, e.keep, e.last, 1'b1, 1'b1}) begin
                        mismatched++;
                        $display("FAIL beat_qfirst: got re=%h im=%h keep=%h last=%b vld=%b%b, required re=%h im=%h keep=%h last=%b",
                                 q1_r_data, q1_i_data, q1_r_keep, q1_r_last, q1_r_vld, q1_i_vld, e.im, e.re, e.keep, e.last);
                    end
                end
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_beat(input logic [127:0] d, input logic l);
        int n;
        n = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        #1;
        while (s_tready !== 1'b1 && n < 40) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (s_tready !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: tready=%b, required 1", s_tready);
        end
        @(negedge clock);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic check_pkt(input string name);
        #1;
        compared++;
        if (pkt_count !== exp_pkt || q1_pkt_count !== exp_pkt) begin
            mismatched++;
            $display("FAIL %s_pkt_count: got %0d/%0d, required %0d", name, pkt_count, q1_pkt_count, exp_pkt);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        s_tdata  = mk_beat(1, 2);
        real_rdy = 1'b1;
        imag_rdy = 1'b1;
        #1;
        compared++;
        if (s_tready !== 1'b0 || q1_s_tready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_tready_comb: got %b/%b, required 0", s_tready, q1_s_tready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            #1;
            compared++;
            if (s_tready !== 1'b0 ||
                {r_data, i_data, r_keep, i_keep, r_vld, i_vld, r_last, i_last, pkt_count} !== '0) begin
                mismatched++;
                $display("FAIL reset_outputs: tready=%b vld=%b%b last=%b%b keep=%h data=%h pkt=%0d, required all 0",
                         s_tready, r_vld, i_vld, r_last, i_last, r_keep, r_data, pkt_count);
            end
        end
        @(negedge clock);
        resetn   = 1'b1;
        s_tvalid = 1'b0;
        exp_pkt  = 16'd0;
        @(negedge clock);
    endtask

    task automatic test_basic_pair();
        real_rdy = 1'b1;
        imag_rdy = 1'b1;
        push_pair(1, 'h101, 5, 'h105, 1'b1);
        send_beat(mk_beat(1, 'h101), 1'b0);
        send_beat(mk_beat(5, 'h105), 1'b1);
        s_tvalid = 1'b0;
        #1;
        compared++;
        if (r_vld !== 1'b1 || r_data !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin
            mismatched++;
            $display("FAIL basic_latency: vld=%b real=%h, required 1 and 0008..0001", r_vld, r_data);
        end
        @(negedge clock);
        wait_empty("basic");
        check_pkt("basic");
    endtask

    task automatic test_odd_packet();
        real_rdy = 1'b1;
        imag_rdy = 1'b1;
        push_pair(1, 'h101, 5, 'h105, 1'b0);
        push_flush(9, 'h109);
        send_beat(mk_beat(1, 'h101), 1'b0);
        send_beat(mk_beat(5, 'h105), 1'b0);
        send_beat(mk_beat(9, 'h109), 1'b1);
        #1;
        compared++;
        if (s_tready !== 1'b0) begin
            mismatched++;
            $display("FAIL odd_flush_tready: got %b, required 0", s_tready);
        end
        @(negedge clock);
        s_tvalid = 1'b0;
        #1;
        compared++;
        if (s_tready !== 1'b1 || r_keep !== 16'h00FF || r_data !== {64'h0, 64'h000C_000B_000A_0009}) begin
            mismatched++;
            $display("FAIL odd_after_flush: tready=%b keep=%h real=%h, required 1, 00ff, padded 000c..0009",
                     s_tready, r_keep, r_data);
        end
        @(negedge clock);
        wait_empty("odd");
        check_pkt("odd");
    endtask

    task automatic test_backpressure();
        real_rdy = 1'b1;
        imag_rdy = 1'b0;
        push_pair('h200, 'h300, 'h204, 'h304, 1'b0);
        send_beat(mk_beat('h200, 'h300), 1'b0);
        send_beat(mk_beat('h204, 'h304), 1'b0);
        send_beat(mk_beat('h208, 'h308), 1'b0);
        s_tdata  = mk_beat('h20C, 'h30C);
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            compared++;
            if (s_tready !== 1'b0 || r_vld !== 1'b1 || i_vld !== 1'b1 ||
                r_data !== {half('h204), half('h200)} || i_data !== {half('h304), half('h300)}) begin
                mismatched++;
                $display("FAIL bp_hold: tready=%b vld=%b%b real=%h imag=%h, required 0, 11, held pair",
                         s_tready, r_vld, i_vld, r_data, i_data);
            end
            @(negedge clock);
        end
        imag_rdy = 1'b1;
        push_pair('h208, 'h308, 'h20C, 'h30C, 1'b1);
        #1;
        compared++;
        if (s_tready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_release_tready: got %b, required 1", s_tready);
        end
        @(negedge clock);
        s_tvalid = 1'b0;
        #1;
        compared++;
        if (r_vld !== 1'b1 || r_data !== {half('h20C), half('h208)}) begin
            mismatched++;
            $display("FAIL bp_no_gap: vld=%b real=%h, required 1 and next pair", r_vld, r_data);
        end
        @(negedge clock);
        wait_empty("bp");
        check_pkt("bp");
    endtask

    task automatic test_streaming();
        real_rdy = 1'b1;
        imag_rdy = 1'b1;
        drain_cyc.delete();
        for (int b = 0; b < 64; b++) begin
            if (b % 2 == 1)
                push_pair(4*(b-1)+1, 'h4000+4*(b-1)+1, 4*b+1, 'h4000+4*b+1, b == 63);
            send_beat(mk_beat(4*b+1, 'h4000+4*b+1), b == 63);
        end
        s_tvalid = 1'b0;
        wait_empty("stream");
        compared++;
        if (drain_cyc.size() != 32) begin
            mismatched++;
            $display("FAIL stream_count: got %0d outputs, required 32", drain_cyc.size());
        end else begin
            compared++;
            if (drain_cyc[31] - drain_cyc[0] != 62) begin
                mismatched++;
                $display("FAIL stream_spacing: span %0d cycles, required 62", drain_cyc[31] - drain_cyc[0]);
            end
        end
        check_pkt("stream");
    endtask

    task automatic test_reset_mid();
        // Reset with a half beat buffered.
        real_rdy = 1'b1;
        imag_rdy = 1'b1;
        send_beat(mk_beat('h500, 'h600), 1'b0);
        s_tvalid = 1'b0;
        resetn   = 1'b0;
        @(negedge clock);
        resetn   = 1'b1;
        exp_pkt  = 16'd0;
        push_pair('h700, 'h800, 'h704, 'h804, 1'b1);
        send_beat(mk_beat('h700, 'h800), 1'b0);
        send_beat(mk_beat('h704, 'h804), 1'b1);
        s_tvalid = 1'b0;
        wait_empty("rst_half");
        check_pkt("rst_half");
        // Reset with an undrained output beat.
        real_rdy = 1'b0;
        imag_rdy = 1'b0;
        send_beat(mk_beat('h900, 'hA00), 1'b0);
        send_beat(mk_beat('h904, 'hA04), 1'b1);
        s_tvalid = 1'b0;
        #1;
        compared++;
        if (r_vld !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_pending_setup: vld=%b, required 1", r_vld);
        end
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn  = 1'b1;
        exp_pkt = 16'd0;
        #1;
        compared++;
        if (r_vld !== 1'b0 || i_vld !== 1'b0 || pkt_count !== 16'd0 || s_tready !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_pending_cleared: vld=%b%b pkt=%0d tready=%b, required 00, 0, 1",
                     r_vld, i_vld, pkt_count, s_tready);
        end
        @(negedge clock);
        real_rdy = 1'b1;
        imag_rdy = 1'b1;
        push_pair('hB00, 'hC00, 'hB04, 'hC04, 1'b1);
        send_beat(mk_beat('hB00, 'hC00), 1'b0);
        send_beat(mk_beat('hB04, 'hC04), 1'b1);
        s_tvalid = 1'b0;
        wait_empty("rst_out");
        check_pkt("rst_out");
    endtask

    initial begin
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_basic_pair();
        test_odd_packet();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
